// File: rtl/soc_reset_seq.sv
// soc_reset_seq: PLL reset/lock sequencer driving the SoC reset on the free-running board clock
module soc_reset_seq #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PLL_RST_CYCLES  = 16,
    parameter int LOCK_TIMEOUT    = 1000000,
    parameter int STRETCH_CYCLES  = 32,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked_i,
    input  logic       key_n_i,
    output logic       pll_rst_o,
    output logic       soc_reset_o,
    output logic       running_o,
    output logic       key_pressed_o,
    output logic [3:0] retry_cnt_o,
    output logic [1:0] cause_o
);
    typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, STRETCH, RUN} state_t;
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PLL_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [1:0] CAUSE_POR = 2'd0;
    localparam logic [1:0] CAUSE_KEY = 2'd1;
    localparam logic [1:0] CAUSE_LOSS = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [DB_W-1:0] db_cnt;
    logic [SYNC_STAGES-1:0] lock_sync;
    logic [SYNC_STAGES-1:0] key_sync;
    logic lock_s;
    logic key_s;

    assign lock_s = lock_sync[SYNC_STAGES-1];
    assign key_s = ~key_sync[SYNC_STAGES-1];

    // key synchroniser holds the raw active-low level, so its idle value is all ones
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_sync <= '0;
            key_sync <= '1;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked_i};
            key_sync <= {key_sync[SYNC_STAGES-2:0], key_n_i};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt <= '0;
            key_pressed_o <= 1'b0;
        end else if (key_s == key_pressed_o) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt <= '0;
            key_pressed_o <= key_s;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PLL_RST;
            cnt <= '0;
            pll_rst_o <= 1'b1;
            soc_reset_o <= 1'b1;
            running_o <= 1'b0;
            retry_cnt_o <= 4'd0;
            cause_o <= CAUSE_POR;
        end else begin
            case (state)
                PLL_RST: begin
                    if (cnt == PLL_LAST) begin
                        state <= WAIT_LOCK;
                        cnt <= '0;
                        pll_rst_o <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= STRETCH;
                        cnt <= '0;
                    end else if (cnt == LOCK_LAST) begin
                        state <= PLL_RST;
                        cnt <= '0;
                        pll_rst_o <= 1'b1;
                        retry_cnt_o <= retry_cnt_o + {3'd0, retry_cnt_o != 4'hF};
                        cause_o <= CAUSE_TIMEOUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STRETCH: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt <= '0;
                        cause_o <= CAUSE_LOSS;
                    end else if (key_pressed_o) begin
                        cnt <= '0;
                    end else if (cnt == STRETCH_LAST) begin
                        state <= RUN;
                        cnt <= '0;
                        soc_reset_o <= 1'b0;
                        running_o <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        cnt <= '0;
                        soc_reset_o <= 1'b1;
                        running_o <= 1'b0;
                        cause_o <= CAUSE_LOSS;
                    end else if (key_pressed_o) begin
                        state <= STRETCH;
                        cnt <= '0;
                        soc_reset_o <= 1'b1;
                        running_o <= 1'b0;
                        cause_o <= CAUSE_KEY;
                    end
                end
                default: begin
                    state <= PLL_RST;
                    cnt <= '0;
                    pll_rst_o <= 1'b1;
                    soc_reset_o <= 1'b1;
                    running_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_soc_reset_seq.sv
// tb_soc_reset_seq: directed latency sequences plus a vector table for retries, saturation and mid-run reset
module tb_soc_reset_seq;
    logic clk = 1'b0;
    logic reset, pll_locked_i, key_n_i;
    logic pll_rst_o, soc_reset_o, running_o, key_pressed_o;
    logic [3:0] retry_cnt_o;
    logic [1:0] cause_o;
    int checks = 0;
    int errors = 0;

    soc_reset_seq #(.DEBOUNCE_CYCLES(8), .LOCK_TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .pll_locked_i(pll_locked_i), .key_n_i(key_n_i),
        .pll_rst_o(pll_rst_o), .soc_reset_o(soc_reset_o), .running_o(running_o),
        .key_pressed_o(key_pressed_o), .retry_cnt_o(retry_cnt_o), .cause_o(cause_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, lock, key_n;
        int n;
        logic pll, soc, run, kp;
        logic [3:0] retry;
        logic [1:0] cause;
    } vec_t;
    vec_t vt[$];

    function automatic vec_t mk(input logic rst, input logic lock, input logic key_n, input int n,
                                input logic pll, input logic soc, input logic run, input logic kp,
                                input logic [3:0] retry, input logic [1:0] cause);
        vec_t v;
        v.rst = rst; v.lock = lock; v.key_n = key_n; v.n = n;
        v.pll = pll; v.soc = soc; v.run = run; v.kp = kp; v.retry = retry; v.cause = cause;
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic sig(input int which);
        return which == 0 ? pll_rst_o : which == 1 ? soc_reset_o : which == 2 ? running_o : key_pressed_o;
    endfunction

    // edges until the selected output reaches val; 0 means the bound expired
    task automatic wait_sig(input int which, input logic val, input int bound, output int n);
        n = 0;
        for (int i = 1; i <= bound; i++) begin
            tick(1);
            if (sig(which) == val) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, pll_fall, soc_fall, bad;
        reset = 1'b1; pll_locked_i = 1'b1; key_n_i = 1'b1;
        tick(3);
        chk("rst_pll", pll_rst_o, 1);
        chk("rst_soc", soc_reset_o, 1);
        chk("rst_run", running_o, 0);
        chk("rst_key", key_pressed_o, 0);
        chk("rst_retry", retry_cnt_o, 0);
        chk("rst_cause", cause_o, 0);
        reset = 1'b0;
        pll_fall = 0; soc_fall = 0;
        for (int e = 1; e <= 200; e++) begin
            tick(1);
            if (!pll_rst_o && pll_fall == 0) pll_fall = e;
            if (!soc_reset_o) begin
                soc_fall = e;
                break;
            end
        end
        chk("pwr_pll_fall", pll_fall, 16);
        chk("pwr_soc_fall", soc_fall, 49);
        chk("pwr_run", running_o, 1);
        chk("pwr_cause", cause_o, 0);
        chk("pwr_retry", retry_cnt_o, 0);

        pll_locked_i = 1'b0;
        wait_sig(1, 1'b1, 50, n);
        chk("loss_latency", n, 3);
        chk("loss_cause", cause_o, 2);
        chk("loss_run", running_o, 0);
        pll_locked_i = 1'b1;
        wait_sig(1, 1'b0, 100, n);
        chk("relock_latency", n, 35);
        chk("relock_run", running_o, 1);

        bad = 0;
        for (int k = 0; k < 4; k++) begin
            key_n_i = 1'b0;
            for (int i = 0; i < 5; i++) begin tick(1); bad += int'(key_pressed_o | soc_reset_o); end
            key_n_i = 1'b1;
            for (int i = 0; i < 5; i++) begin tick(1); bad += int'(key_pressed_o | soc_reset_o); end
        end
        chk("bounce_ignored", bad, 0);
        key_n_i = 1'b0;
        wait_sig(3, 1'b1, 50, n);
        chk("key_debounce", n, 10);
        chk("key_soc_before", soc_reset_o, 0);
        tick(1);
        chk("key_soc", soc_reset_o, 1);
        chk("key_cause", cause_o, 1);
        chk("key_run", running_o, 0);
        tick(100);
        chk("key_hold_soc", soc_reset_o, 1);
        key_n_i = 1'b1;
        wait_sig(1, 1'b0, 100, n);
        chk("key_release", n, 42);

        key_n_i = 1'b0;
        tick(8);
        pll_locked_i = 1'b0;
        tick(3);
        chk("sim_soc", soc_reset_o, 1);
        chk("sim_cause", cause_o, 2);
        chk("sim_pll", pll_rst_o, 0);
        chk("sim_kp", key_pressed_o, 1);
        key_n_i = 1'b1;
        pll_locked_i = 1'b1;
        wait_sig(1, 1'b0, 100, n);
        chk("sim_recover", n, 42);

        vt.push_back(mk(1, 0, 1, 3,   1, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 15,  1, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 1,   0, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 63,  0, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 1, 1,   1, 1, 0, 0, 1, 3));
        vt.push_back(mk(0, 0, 1, 15,  1, 1, 0, 0, 1, 3));
        vt.push_back(mk(0, 0, 1, 1,   0, 1, 0, 0, 1, 3));
        vt.push_back(mk(0, 0, 1, 64,  1, 1, 0, 0, 2, 3));
        vt.push_back(mk(0, 0, 1, 960, 1, 1, 0, 0, 14, 3));
        vt.push_back(mk(0, 0, 1, 80,  1, 1, 0, 0, 15, 3));
        vt.push_back(mk(0, 0, 1, 80,  1, 1, 0, 0, 15, 3));
        vt.push_back(mk(0, 0, 1, 16,  0, 1, 0, 0, 15, 3));
        vt.push_back(mk(0, 1, 1, 2,   0, 1, 0, 0, 15, 3));
        vt.push_back(mk(0, 1, 1, 1,   0, 1, 0, 0, 15, 3));
        vt.push_back(mk(0, 1, 1, 31,  0, 1, 0, 0, 15, 3));
        vt.push_back(mk(0, 1, 1, 1,   0, 0, 1, 0, 15, 3));
        vt.push_back(mk(0, 1, 0, 10,  0, 0, 1, 1, 15, 3));
        vt.push_back(mk(0, 1, 0, 1,   0, 1, 0, 1, 15, 1));
        vt.push_back(mk(1, 1, 0, 1,   1, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 1, 1, 1,   1, 1, 0, 0, 0, 0));
        for (int i = 0; i < vt.size(); i++) begin
            reset = vt[i].rst; pll_locked_i = vt[i].lock; key_n_i = vt[i].key_n;
            tick(vt[i].n);
            chk($sformatf("v%0d_pll", i), pll_rst_o, vt[i].pll);
            chk($sformatf("v%0d_soc", i), soc_reset_o, vt[i].soc);
            chk($sformatf("v%0d_run", i), running_o, vt[i].run);
            chk($sformatf("v%0d_kp", i), key_pressed_o, vt[i].kp);
            chk($sformatf("v%0d_retry", i), retry_cnt_o, vt[i].retry);
            chk($sformatf("v%0d_cause", i), cause_o, vt[i].cause);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/soc_reset_seq.md
Name: soc_reset_seq

Overview:
- Reset sequencer between the board clock/PLL and the mips32r1 SoC on the DE1-SoC top.
- Pulses the PLL reset and waits for PLL lock, with timeout and retry.
- Stretches SoC reset after lock. Re-asserts SoC reset on lock loss or on a debounced KEY press.
- Runs on the free-running board clock (CLOCK_50), never on the PLL output; drives the SoC reset in place of the slow-clock reset counter.

Parameters:
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser (≥2).
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles before the debounced key changes (≥1).
- PLL_RST_CYCLES, 16: cycles pll_rst_o is held high per attempt (≥SYNC_STAGES).
- LOCK_TIMEOUT, 1000000: cycles waited for lock before retrying the PLL reset (≥1).
- STRETCH_CYCLES, 32: cycles SoC reset is held after lock or key release (≥1).
- CNT_W, 20: shared state-counter width; must hold max(PLL_RST_CYCLES, LOCK_TIMEOUT, STRETCH_CYCLES) - 1.

Ports:
- clk, in, 1: free-running board clock.
- reset, in, 1: sequencer reset.
- pll_locked_i, in, 1: PLL lock, asynchronous.
- key_n_i, in, 1: push-button, active-low, asynchronous, bouncy.
- pll_rst_o, out, 1: PLL reset request.
- soc_reset_o, out, 1: SoC reset, active-high.
- running_o, out, 1: high only in RUN.
- key_pressed_o, out, 1: debounced key level, 1 = pressed.
- retry_cnt_o, out, 4: PLL reset retries, saturating at 15.
- cause_o, out, 2: last reset cause. 0 = power-on, 1 = key, 2 = lock loss, 3 = lock timeout.

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. Reset is sampled at the clock edge; no asynchronous paths.
- Values after reset:
  - state PLL_RST, counter 0.
  - pll_rst_o=1, soc_reset_o=1, running_o=0, key_pressed_o=0, retry_cnt_o=0, cause_o=0.
  - lock synchroniser all 0; key synchroniser all 1.
- Reset asserted mid-operation restores all of the above on the next edge, including retry_cnt_o and cause_o.
- Synchronisers:
  - lock_s = pll_locked_i delayed by SYNC_STAGES flops.
  - key_s = ~key_n_i delayed by SYNC_STAGES flops.
- Debounce:
  - Counter clears whenever key_s == key_pressed_o.
  - While they differ, the counter increments.
  - On the DEBOUNCE_CYCLES-th consecutive differing cycle, key_pressed_o <= key_s and the counter clears.
  - Any glitch shorter than that leaves key_pressed_o unchanged.
- FSM: all outputs are registered and update on the same edge as state. The counter clears on every state change.
  - PLL_RST: pll_rst_o=1, soc_reset_o=1. Stay exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK.
  - WAIT_LOCK: pll_rst_o=0, soc_reset_o=1.
    - If lock_s: go to STRETCH.
    - Else if counter==LOCK_TIMEOUT-1: go to PLL_RST; retry_cnt_o+1 (saturating); cause_o=3.
    - Key is ignored.
  - STRETCH: soc_reset_o=1. Priority order:
    1. !lock_s: go to WAIT_LOCK, cause_o=2.
    2. key_pressed_o: stay, counter held at 0 (reset extends while the button is held).
    3. counter==STRETCH_CYCLES-1: go to RUN.
  - RUN: soc_reset_o=0, running_o=1. Priority order:
    1. !lock_s: go to WAIT_LOCK, cause_o=2. Lock loss beats key.
    2. key_pressed_o: go to STRETCH, cause_o=1.
- Latencies:
  - Power-up with lock already high: soc_reset_o falls on edge PLL_RST_CYCLES+1+STRETCH_CYCLES after reset deasserts (49 with defaults).
  - Lock loss in RUN: soc_reset_o rises SYNC_STAGES+1 edges after pll_locked_i falls.
  - Key press in RUN: soc_reset_o rises SYNC_STAGES+DEBOUNCE_CYCLES+1 edges after key_n_i falls and stays low.
- Lock that returns while in PLL_RST is only acted on in WAIT_LOCK.
- A lock pulse shorter than one clock may be missed; this is acceptable.
- Counter arithmetic is CNT_W bits unsigned, compared with equality. The counter never wraps because every state exits at its limit.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=8, LOCK_TIMEOUT=64, other parameters at default.
- Power-up: pll_locked_i=1 from t0, reset high 3 cycles then low → pll_rst_o high 16 cycles; soc_reset_o falls on edge 49; running_o=1; cause_o=0; retry_cnt_o=0.
- No lock: pll_locked_i=0 → pll_rst_o pulses 16 cycles every 80 cycles; retry_cnt_o 1, 2, … saturates at 15; cause_o=3. Raise lock → RUN 33 cycles after entering WAIT_LOCK with lock seen.
- Lock loss: in RUN, drop pll_locked_i → soc_reset_o=1 at edge 3, cause_o=2. Restore lock → soc_reset_o falls 1+32 cycles after lock_s rises.
- Key bounce: in RUN, toggle key_n_i low/high with 5-cycle pulses → no change. Hold low → key_pressed_o=1 after 2+8 edges; soc_reset_o=1 next edge, cause_o=1. Hold 100 cycles then release → soc_reset_o falls 10+32 cycles after release.
- Simultaneous events: debounced key and lock loss in the same RUN cycle → WAIT_LOCK, cause_o=2.
- Mid-sequence reset: reset asserted in STRETCH → next edge state PLL_RST, all outputs at reset values, retry_cnt_o=0.
